// File: rtl/sqacc_pkg.sv
// sqacc_pkg: shared types and widths for the square_accumulator slice.
//   state_e     : frame FSM states (ACCUM collects squares, HOLD presents sum)
//   SQ_W        : width of one square of a 3-bit operand
//   A_W         : operand width
//   FRAME_CNT_W : width of the delivered-frame counter
package sqacc_pkg;
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   localparam int SQ_W        = 6;
   localparam int A_W         = 3;
   localparam int FRAME_CNT_W = 8;
endpackage

// File: rtl/square_accumulator_if.sv
// square_accumulator_if: operand-in and frame-out handshakes.
//   in_valid/in_ready/a           : operand stream (producer -> accumulator)
//   out_valid/out_ready/sum       : frame result (accumulator -> consumer)
//   frame_cnt                     : completed frames delivered, wraps 255->0
// Modports: master = producer/consumer side, slave = accumulator side.
interface square_accumulator_if
   import sqacc_pkg::*;
#(
   parameter int ACC_W = 9
) ();
   logic                   in_valid;
   logic                   in_ready;
   logic [A_W-1:0]         a;
   logic                   out_valid;
   logic                   out_ready;
   logic [ACC_W-1:0]       sum;
   logic [FRAME_CNT_W-1:0] frame_cnt;

   modport master (
      output in_valid, a, out_ready,
      input  in_ready, out_valid, sum, frame_cnt
   );

   modport slave (
      input  in_valid, a, out_ready,
      output in_ready, out_valid, sum, frame_cnt
   );
endinterface

// File: rtl/sq3_unit.sv
// sq3_unit: combinational 3-bit -> 6-bit squarer.
//   a_i  : unsigned operand
//   sq_o : a_i * a_i (0,1,4,9,16,25,36,49)
module sq3_unit
   import sqacc_pkg::*;
(
   input  logic [A_W-1:0]  a_i,
   output logic [SQ_W-1:0] sq_o
);
   always_comb begin
      sq_o = '0;
      case (a_i)
         3'd0:    sq_o = 6'd0;
         3'd1:    sq_o = 6'd1;
         3'd2:    sq_o = 6'd4;
         3'd3:    sq_o = 6'd9;
         3'd4:    sq_o = 6'd16;
         3'd5:    sq_o = 6'd25;
         3'd6:    sq_o = 6'd36;
         3'd7:    sq_o = 6'd49;
         default: sq_o = '0;
      endcase
   end
endmodule

// File: rtl/square_accumulator.sv
// square_accumulator: sums N_SAMPLES squares of a 3-bit operand stream into
// one frame result and presents it on a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   clr   : synchronous frame abort (ignored while a result is held)
//   bus   : square_accumulator_if.slave (operand in, frame sum out,
//           delivered-frame counter)
// Optional feature: define SQACC_SAT_EN to clamp each addition at
// 2^ACC_W - 1 instead of wrapping modulo 2^ACC_W.
module square_accumulator
   import sqacc_pkg::*;
#(
   parameter int N_SAMPLES = 8,
   parameter int ACC_W     = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   square_accumulator_if.slave   bus
);
   localparam int               CNT_W = $clog2(N_SAMPLES + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_SAMPLES - 1);

   state_e                 state_q;
   logic [ACC_W-1:0]       acc_q;
   logic [ACC_W-1:0]       acc_d;
   logic [ACC_W-1:0]       sum_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [FRAME_CNT_W-1:0] frame_cnt_q;
   logic                   out_valid_q;
   logic [SQ_W-1:0]        sq;

   sq3_unit u_sq (
      .a_i  (bus.a),
      .sq_o (sq)
   );

   // Ready depends only on state and clr, never on in_valid.
   assign bus.in_ready  = rst_n && (state_q == ACCUM) && !clr;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.frame_cnt = frame_cnt_q;

`ifdef SQACC_SAT_EN
   localparam int SUM_W = ACC_W + 1;
   logic [SUM_W-1:0] acc_wide;

   // One extra bit catches the carry; once clamped, acc stays at all-ones
   // because every later square is non-negative.
   always_comb begin
      acc_wide = {1'b0, acc_q} + SUM_W'(sq);
      acc_d    = acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];
   end
`else
   always_comb begin
      acc_d = acc_q + ACC_W'(sq);
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         frame_cnt_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (clr) begin
                  acc_q <= '0;
                  cnt_q <= '0;
               end else if (bus.in_valid) begin
                  if (cnt_q == LAST) begin
                     sum_q       <= acc_d;
                     acc_q       <= '0;
                     cnt_q       <= '0;
                     out_valid_q <= 1'b1;
                     state_q     <= HOLD;
                  end else begin
                     acc_q <= acc_d;
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
                  state_q     <= ACCUM;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_square_accumulator.sv
module tb_square_accumulator;
   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       in_valid;
   logic [2:0] a;
   logic       out_ready;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   square_accumulator_if #(.ACC_W(9)) bus9 ();
   square_accumulator_if #(.ACC_W(8)) bus8 ();

   assign bus9.in_valid  = in_valid;
   assign bus9.a         = a;
   assign bus9.out_ready = out_ready;
   assign bus8.in_valid  = in_valid;
   assign bus8.a         = a;
   assign bus8.out_ready = out_ready;

   square_accumulator #(.N_SAMPLES(8), .ACC_W(9)) dut9 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus9.slave)
   );

   square_accumulator #(.N_SAMPLES(8), .ACC_W(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: frame-level bookkeeping with plain integers.
   bit m_hold;
   int m_cnt;
   int m_total;
   int m_sum9;
   int m_sum8;
   int m_fc;

   function automatic int fold(input int total, input int w);
      int lim;
      lim = (1 << w) - 1;
`ifdef SQACC_SAT_EN
      return (total > lim) ? lim : total;
`else
      return total % (1 << w);
`endif
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // One clock: check ready against the model, advance model and DUT,
   // then check registered outputs just after the edge.
   task automatic tick();
      int ir_exp;
      #1;
      ir_exp = (rst_n && !m_hold && !clr) ? 1 : 0;
      chk("in_ready9", int'(bus9.in_ready), ir_exp);
      chk("in_ready8", int'(bus8.in_ready), ir_exp);
      if (!rst_n) begin
         m_hold = 0; m_cnt = 0; m_total = 0; m_sum9 = 0; m_sum8 = 0; m_fc = 0;
      end else if (m_hold) begin
         if (out_ready) begin
            m_hold = 0;
            m_fc   = (m_fc + 1) % 256;
         end
      end else if (clr) begin
         m_cnt = 0; m_total = 0;
      end else if (in_valid) begin
         m_total += int'(a) * int'(a);
         m_cnt++;
         if (m_cnt == 8) begin
            m_sum9 = fold(m_total, 9);
            m_sum8 = fold(m_total, 8);
            m_hold = 1; m_cnt = 0; m_total = 0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("out_valid9", int'(bus9.out_valid), int'(m_hold));
      chk("out_valid8", int'(bus8.out_valid), int'(m_hold));
      chk("sum9", int'(bus9.sum), m_sum9);
      chk("sum8", int'(bus8.sum), m_sum8);
      chk("frame_cnt9", int'(bus9.frame_cnt), m_fc);
      chk("frame_cnt8", int'(bus8.frame_cnt), m_fc);
   endtask

   task automatic send(input int unsigned val, input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         a        = 3'(val);
         tick();
      end
      in_valid = 1'b0;
   endtask

   typedef struct {
      int unsigned a[8];
      int          exp9;
      int          exp8;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int rise[$];
      bit prev_ov;
      int fc0;
      int lim8;

      lim8 = 255;
      vecs[0].a = '{1, 2, 3, 4, 5, 6, 7, 0}; vecs[0].exp9 = 140; vecs[0].exp8 = 140;
`ifdef SQACC_SAT_EN
      vecs[1].a = '{7, 7, 7, 7, 7, 7, 7, 7}; vecs[1].exp9 = 392; vecs[1].exp8 = lim8;
      vecs[6].a = '{6, 6, 6, 6, 6, 6, 6, 6}; vecs[6].exp9 = 288; vecs[6].exp8 = lim8;
`else
      vecs[1].a = '{7, 7, 7, 7, 7, 7, 7, 7}; vecs[1].exp9 = 392; vecs[1].exp8 = 136;
      vecs[6].a = '{6, 6, 6, 6, 6, 6, 6, 6}; vecs[6].exp9 = 288; vecs[6].exp8 = 32;
`endif
      vecs[2].a = '{1, 1, 1, 1, 1, 1, 1, 1}; vecs[2].exp9 = 8;   vecs[2].exp8 = 8;
      vecs[3].a = '{2, 2, 2, 2, 2, 2, 2, 2}; vecs[3].exp9 = 32;  vecs[3].exp8 = 32;
      vecs[4].a = '{0, 0, 0, 0, 0, 0, 0, 0}; vecs[4].exp9 = 0;   vecs[4].exp8 = 0;
      vecs[5].a = '{7, 0, 7, 0, 7, 0, 7, 0}; vecs[5].exp9 = 196; vecs[5].exp8 = 196;
      vecs[7].a = '{5, 5, 5, 5, 5, 5, 5, 5}; vecs[7].exp9 = 200; vecs[7].exp8 = 200;

      m_hold = 0; m_cnt = 0; m_total = 0; m_sum9 = 0; m_sum8 = 0; m_fc = 0;
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; a = '0; out_ready = 1'b0;
      tick();
      tick();
      chk("rst_out_valid", int'(bus9.out_valid), 0);
      chk("rst_sum", int'(bus9.sum), 0);
      chk("rst_frame_cnt", int'(bus9.frame_cnt), 0);
      rst_n = 1'b1;
      #1;
      chk("ready_after_rst", int'(bus9.in_ready), 1);

      // Table-driven frames with consumer always ready.
      out_ready = 1'b1;
      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            a        = 3'(vecs[v].a[i]);
            tick();
         end
         in_valid = 1'b0;
         chk("vec_ov", int'(bus9.out_valid), 1);
         chk("vec_sum9", int'(bus9.sum), vecs[v].exp9);
         chk("vec_sum8", int'(bus8.sum), vecs[v].exp8);
         tick();
         chk("vec_ov_1cyc", int'(bus9.out_valid), 0);
      end
      chk("vec_frames", int'(bus9.frame_cnt), 8);

      // Three back-to-back frames of 7s: results nine cycles apart.
      fc0 = int'(bus9.frame_cnt);
      prev_ov = bus9.out_valid;
      in_valid = 1'b1; a = 3'd7; out_ready = 1'b1;
      for (int i = 0; i < 27; i++) begin
         tick();
         if (bus9.out_valid && !prev_ov) rise.push_back(cyc);
         prev_ov = bus9.out_valid;
      end
      in_valid = 1'b0;
      tick();
      chk("b2b_frames", rise.size(), 3);
      if (rise.size() == 3) begin
         chk("b2b_gap1", rise[1] - rise[0], 9);
         chk("b2b_gap2", rise[2] - rise[1], 9);
      end
      chk("b2b_fcnt", int'(bus9.frame_cnt) - fc0, 3);

      // Backpressure: result held five cycles, taken on the sixth.
      out_ready = 1'b0;
      send(4, 8);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_ready", int'(bus9.in_ready), 0);
         chk("bp_sum", int'(bus9.sum), 128);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      chk("bp_ready_back", int'(bus9.in_ready), 1);
      out_ready = 1'b1;

      // clr mid-frame with in_valid high: that sample is dropped.
      send(3, 4);
      clr = 1'b1; in_valid = 1'b1; a = 3'd3;
      tick();
      clr = 1'b0;
      send(1, 8);
      chk("clr_sum9", int'(bus9.sum), 8);
      chk("clr_sum8", int'(bus8.sum), 8);
      tick();

      // Reset mid-frame clears everything, including frame_cnt.
      send(2, 5);
      rst_n = 1'b0;
      tick();
      chk("rst_mid_ov", int'(bus9.out_valid), 0);
      chk("rst_mid_fcnt", int'(bus9.frame_cnt), 0);
      rst_n = 1'b1;
      send(2, 8);
      chk("rst_mid_sum", int'(bus9.sum), 32);
      tick();
      chk("rst_mid_fcnt1", int'(bus9.frame_cnt), 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         in_valid  = ($urandom_range(3, 0) != 0);
         a         = 3'($urandom_range(7, 0));
         out_ready = $urandom_range(1, 0) == 1;
         clr       = ($urandom_range(15, 0) == 0);
         rst_n     = ($urandom_range(199, 0) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/square_accumulator.md
# square_accumulator

Sequential sum-of-squares stage that sits directly downstream of the 3-bit squarer. It accepts a stream of 3-bit operands over a valid/ready handshake and squares each one through the squarer. It accumulates N_SAMPLES squares into one frame result and presents that result on a second valid/ready handshake. Its main use is energy/variance measurement on small-magnitude sample streams.

## Interface
- N_SAMPLES, 8: squares per frame; legal range 2..256.
- ACC_W, 9: accumulator/result width; full range requires ACC_W >= 6 + clog2(N_SAMPLES).
- clk  in  1: rising-edge clock.
- rst_n  in  1: one clock; reset is synchronous and active-low.
- clr  in  1: synchronous frame abort; discards partial sum and count.
- in_valid  in  1: operand a is valid.
- in_ready  out  1: stage can accept an operand.
- a  in  3: unsigned operand (a2..a0).
- out_valid  out  1: sum holds a completed frame.
- out_ready  in  1: consumer takes sum.
- sum  out  ACC_W: frame sum of squares.
- frame_cnt  out  8: completed frames delivered, wraps 255->0.

## Operation
- States: ACCUM and HOLD. Reset enters ACCUM.
- ACCUM:
  - in_ready = !clr.
  - An operand is accepted when in_valid && in_ready. On accept: acc += a*a (6-bit square, zero-extended) and cnt++.
  - If the accept brings cnt to N_SAMPLES: sum <= acc + a*a, acc <= 0, cnt <= 0, and the state moves to HOLD.
- HOLD:
  - out_valid = 1, in_ready = 0, sum stable.
  - When out_ready is high: out_valid drops next cycle, frame_cnt++, and the state returns to ACCUM.
- clr:
  - In ACCUM: acc <= 0, cnt <= 0. An in_valid in the same cycle is not accepted, because in_ready is low.
  - In HOLD: clr is ignored. A completed frame is never discarded.
- Arithmetic: acc wraps modulo 2^ACC_W unless SQACC_SAT_EN is defined.
- Reset values: out_valid 0, sum 0, frame_cnt 0, acc 0, cnt 0. in_ready is 0 while rst_n is low and 1 in the first cycle after release, provided clr is low.

## Timing
- Combinational input-to-sum path is square plus add; no pipeline register on the square.
- out_valid rises the cycle after the N_SAMPLES-th accept.
- Minimum frame period is N_SAMPLES + 1 cycles: N accepts, then 1 HOLD cycle with out_ready held high.
- in_ready depends combinationally only on state and clr, never on in_valid.
- out_valid and sum are registered.
- Backpressure: HOLD persists for any number of cycles with sum unchanged.
- rst_n low mid-frame or in HOLD: all state returns to reset values on that edge. The pending frame is lost and frame_cnt is cleared.

## Configuration
- SQACC_SAT_EN defined: each addition clamps at 2^ACC_W - 1. The clamped value persists for the rest of the frame.
- SQACC_SAT_EN undefined: plain modulo-2^ACC_W wrap, no compare logic.

## Structure
- Shared package `sqacc_pkg`:
  - state enum {ACCUM, HOLD}
  - SQ_W = 6
  - A_W = 3
  - FRAME_CNT_W = 8
- Sub-module `sq3_unit`: combinational 3-bit -> 6-bit squarer, instantiated once on a. Matches the existing squarer's truth table: 0,1,4,9,16,25,36,49.
- Counter width is clog2(N_SAMPLES+1), derived locally.

## Test plan
- Defaults; stream a = 1,2,3,4,5,6,7,0 with in_valid held high and out_ready high. Required: sum = 140 with out_valid high for 1 cycle, frame_cnt = 1.
- Eight samples of a = 7 back to back, repeated for 3 frames. Required: sum = 392 each frame, frames spaced 9 cycles apart, frame_cnt = 3.
- Complete a frame with out_ready low for 5 cycles. Required: in_ready = 0 and sum constant for all 5 cycles; accept on the 6th cycle; in_ready returns 1 the next cycle.
- Accept 4 samples of a = 3, pulse clr with in_valid high, then send 8 samples of a = 1. Required: the clr-cycle sample is not accepted; the next sum = 8.
- ACC_W = 8, eight samples of a = 7. Required: sum = 255 with SQACC_SAT_EN defined; sum = 136 without it.
- Assert rst_n low for 1 cycle after 5 accepted samples, then send 8 samples of a = 2. Required: out_valid = 0 during reset; the next sum = 32; frame_cnt = 1.
